// File: rtl/jpeg_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jpeg_sched_pkg                                                           |
// | Shared types, component codes and block-order lookup for the scheduler.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package jpeg_sched_pkg;

    localparam int BLK_SAMPLES = 64;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SRC = 3'd1,
        ST_STREAM   = 3'd2,
        ST_NEXT     = 3'd3,
        ST_DONE     = 3'd4,
        ST_MARK     = 3'd5
    } sched_state_e;

    // 4:2:0 order is Y0 Y1 Y2 Y3 Cb Cr; 4:4:4 order is Y Cb Cr.
    function automatic logic [1:0] blk_to_comp(input logic [2:0] blk_no, input logic sub420);
        logic [1:0] comp;
        comp = COMP_CR;
        if (sub420) begin
            if (blk_no < 3'd4)
                comp = COMP_Y;
            else if (blk_no == 3'd4)
                comp = COMP_CB;
        end else begin
            if (blk_no == 3'd0)
                comp = COMP_Y;
            else if (blk_no == 3'd1)
                comp = COMP_CB;
        end
        return comp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_blk_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jpeg_blk_counter                                                         |
// | Raster sample index within one 8x8 block, advanced on each handshake.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module jpeg_blk_counter
    import jpeg_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    output logic [5:0] idx,
    output logic       sob,
    output logic       eob
);

    logic [5:0] idx_q;
    logic [5:0] idx_d;

    // The index wraps 63 -> 0 on the last transfer, so the next block starts at 0.
    always_comb begin
        idx_d = idx_q;
        if (clr)
            idx_d = '0;
        else if (adv)
            idx_d = idx_q + 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

    assign idx = idx_q;
    assign sob = (idx_q == 6'd0);
    assign eob = (idx_q == 6'(BLK_SAMPLES - 1));

endmodule
`default_nettype wire

// File: rtl/jpeg_mcu_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jpeg_mcu_scheduler                                                       |
// | Sequences Y/Cb/Cr 8x8 blocks in MCU order into the shared DCT datapath.  |
// | Optional restart-marker handshake: define JPEG_SCHED_RESTART_EN.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module jpeg_mcu_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter int SUBSAMP_420  = 1,
    parameter int MCU_CNT_W    = 16,
    parameter int RST_INTERVAL = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MCU_CNT_W-1:0] mcus_per_frame,
    input  logic [2:0]           blk_valid,
    output logic [2:0]           blk_ack,
    output logic [1:0]           rd_comp,
    output logic [5:0]           rd_idx,
    output logic                 dct_valid,
    input  logic                 dct_ready,
    output logic                 dct_sob,
    output logic                 dct_eob,
    output logic                 qtab_sel,
    output logic                 busy,
    output logic                 mcu_done,
    output logic                 frame_done
`ifdef JPEG_SCHED_RESTART_EN
    ,
    output logic                 rst_mark_req,
    input  logic                 rst_mark_ack,
    output logic [2:0]           rst_mark_num
`endif
);

    localparam logic       c_sub420   = (SUBSAMP_420 != 0);
    localparam logic [2:0] c_last_blk = c_sub420 ? 3'd5 : 3'd2;

    if (RST_INTERVAL < 1) begin : g_bad_rst_interval
        $error("RST_INTERVAL must be at least 1");
    end

    sched_state_e         state_q, state_d;
    logic [2:0]           blk_no_q, blk_no_d;
    logic [MCU_CNT_W-1:0] mcu_cnt_q, mcu_cnt_d;
    logic [MCU_CNT_W-1:0] mcu_tot_q, mcu_tot_d;

    logic                 w_accept;
    logic [1:0]           w_comp;
    logic                 w_src_valid;
    logic                 w_last_blk;
    logic [MCU_CNT_W-1:0] w_mcu_inc;
    logic                 w_last_mcu;
    logic                 w_xfer;
    logic                 w_sob;
    logic                 w_eob;

    assign w_accept   = (state_q == ST_IDLE) && start;
    assign w_comp     = blk_to_comp(blk_no_q, c_sub420);
    assign w_last_blk = (blk_no_q == c_last_blk);
    assign w_mcu_inc  = mcu_cnt_q + MCU_CNT_W'(1);
    assign w_last_mcu = (w_mcu_inc == mcu_tot_q);
    assign w_xfer     = (state_q == ST_STREAM) && dct_ready;

    always_comb begin
        case (w_comp)
            COMP_Y:  w_src_valid = blk_valid[0];
            COMP_CB: w_src_valid = blk_valid[1];
            default: w_src_valid = blk_valid[2];
        endcase
    end

    jpeg_blk_counter u_blk_counter (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .adv (w_xfer),
        .idx (rd_idx),
        .sob (w_sob),
        .eob (w_eob)
    );

`ifdef JPEG_SCHED_RESTART_EN
    localparam int c_rcnt_w = (RST_INTERVAL > 1) ? $clog2(RST_INTERVAL) : 1;

    logic [c_rcnt_w-1:0] rcnt_q, rcnt_d;
    logic [2:0]          mnum_q, mnum_d;
    logic                w_mark;

    // rcnt counts completed MCUs since the last marker.
    assign w_mark = (rcnt_q == c_rcnt_w'(RST_INTERVAL - 1));

    always_comb begin
        rcnt_d = rcnt_q;
        mnum_d = mnum_q;
        if (w_accept) begin
            rcnt_d = '0;
            mnum_d = '0;
        end else begin
            if (state_q == ST_NEXT && w_last_blk)
                rcnt_d = w_mark ? '0 : rcnt_q + c_rcnt_w'(1);
            if (state_q == ST_MARK && rst_mark_ack)
                mnum_d = mnum_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
            mnum_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            mnum_q <= mnum_d;
        end
    end

    assign rst_mark_req = (state_q == ST_MARK);
    assign rst_mark_num = mnum_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_WAIT_SRC;
            ST_WAIT_SRC: if (w_src_valid) state_d = ST_STREAM;
            ST_STREAM:   if (dct_ready && w_eob) state_d = ST_NEXT;
            ST_NEXT: begin
                if (w_last_blk && w_last_mcu)
                    state_d = ST_DONE;
`ifdef JPEG_SCHED_RESTART_EN
                else if (w_last_blk && w_mark)
                    state_d = ST_MARK;
`endif
                else
                    state_d = ST_WAIT_SRC;
            end
            ST_DONE:     state_d = ST_IDLE;
`ifdef JPEG_SCHED_RESTART_EN
            ST_MARK:     if (rst_mark_ack) state_d = ST_WAIT_SRC;
`endif
            default:     state_d = ST_IDLE;
        endcase
    end

    // A requested count of zero still encodes one MCU.
    always_comb begin
        blk_no_d  = blk_no_q;
        mcu_cnt_d = mcu_cnt_q;
        mcu_tot_d = mcu_tot_q;
        if (w_accept) begin
            blk_no_d  = '0;
            mcu_cnt_d = '0;
            mcu_tot_d = (mcus_per_frame == '0) ? MCU_CNT_W'(1) : mcus_per_frame;
        end else if (state_q == ST_NEXT) begin
            if (w_last_blk) begin
                blk_no_d  = '0;
                mcu_cnt_d = w_mcu_inc;
            end else begin
                blk_no_d  = blk_no_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_no_q  <= '0;
            mcu_cnt_q <= '0;
            mcu_tot_q <= '0;
        end else begin
            blk_no_q  <= blk_no_d;
            mcu_cnt_q <= mcu_cnt_d;
            mcu_tot_q <= mcu_tot_d;
        end
    end

    always_comb begin
        blk_ack    = 3'b000;
        dct_valid  = (state_q == ST_STREAM);
        mcu_done   = (state_q == ST_NEXT) && w_last_blk;
        frame_done = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        if (state_q == ST_NEXT) begin
            case (w_comp)
                COMP_Y:  blk_ack = 3'b001;
                COMP_CB: blk_ack = 3'b010;
                default: blk_ack = 3'b100;
            endcase
        end
    end

    assign rd_comp  = w_comp;
    assign qtab_sel = (w_comp != COMP_Y);
    assign dct_sob  = dct_valid && w_sob;
    assign dct_eob  = dct_valid && w_eob;

endmodule
`default_nettype wire

// File: doc/jpeg_mcu_scheduler.md
Name: jpeg_mcu_scheduler

Overview:
- Sequences 8x8 blocks from the per-component block buffers (Y, Cb, Cr) into the single shared forward-DCT/quantiser datapath.
- Enforces MCU block order:
  - 4:2:0 mode: Y0 Y1 Y2 Y3 Cb Cr.
  - 4:4:4 mode: Y Cb Cr.
- Generates the 64-sample read index, quant-table select, MCU/frame boundary strobes.
- Sits between the colour-convert/buffer stage and the DCT pipeline; one instance per encoder core.

Parameters:
- SUBSAMP_420, 1, 1 = 6 blocks/MCU (4 Y + Cb + Cr); 0 = 3 blocks/MCU.
- MCU_CNT_W, 16, width of the MCU counter and mcus_per_frame.
- RST_INTERVAL, 8, MCUs between restart markers (used only with the optional feature); must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise.
- mcus_per_frame  in  MCU_CNT_W  MCUs in the frame, sampled on start; 0 is treated as 1.
- blk_valid  in  3  per component {Cr,Cb,Y}: buffer holds a complete 8x8 block.
- blk_ack  out  3  one-hot, one-cycle pulse: releases the consumed block to its buffer.
- rd_comp  out  2  component being read: 0=Y, 1=Cb, 2=Cr.
- rd_idx  out  6  sample index 0..63, raster order.
- dct_valid  out  1  rd_comp/rd_idx valid toward the DCT.
- dct_ready  in  1  DCT accepts the sample this cycle.
- dct_sob  out  1  high with rd_idx==0.
- dct_eob  out  1  high with rd_idx==63.
- qtab_sel  out  1  0 = luma table, 1 = chroma table; stable for the whole block.
- busy  out  1  high from the cycle after an accepted start until the DONE→IDLE transition.
- mcu_done  out  1  one-cycle pulse after the last block of an MCU is fully accepted.
- frame_done  out  1  one-cycle pulse in state DONE.

Behaviour:
- Reset: state=IDLE; all outputs 0; counters (blk_no, rd_idx, mcu_cnt) cleared. Reset mid-block abandons the block with no blk_ack.
- States: IDLE → WAIT_SRC → STREAM → NEXT → (WAIT_SRC | DONE) → IDLE.
- IDLE: on start, latch mcus_per_frame, clear counters, go to WAIT_SRC next cycle.
- WAIT_SRC:
  - Component for blk_no = 0..3 is Y, 4 is Cb, 5 is Cr (4:2:0); blk_no = 0,1,2 is Y,Cb,Cr (4:4:4).
  - Stay until blk_valid[comp] = 1, then go to STREAM with rd_idx=0.
  - Valid flags of other components are ignored; no reordering.
- STREAM:
  - dct_valid=1.
  - rd_idx advances only on dct_valid & dct_ready; outputs held stable while ready is low.
  - Transfer with rd_idx==63 → NEXT.
- NEXT (1 cycle):
  - blk_ack[comp]=1, increment blk_no.
  - If the block was last in the MCU: mcu_done=1, blk_no←0, mcu_cnt+1.
  - If mcu_cnt+1 == latched count → DONE, else → WAIT_SRC.
- DONE (1 cycle): frame_done=1, → IDLE.
- Throughput: 64 + 2 cycles per block minimum; first dct_valid occurs 2 cycles after start when blk_valid[0] is already high.
- start while busy: ignored, no effect on counters.
- mcu_cnt wraps are impossible: comparison uses equality on the latched value.

Optional Feature:
- Macro JPEG_SCHED_RESTART_EN.
- When defined:
  - Adds ports rst_mark_req (out, 1) and rst_mark_ack (in, 1), plus a 3-bit rst_mark_num output (RSTn modulo 8).
  - After every RST_INTERVAL-th MCU that is not the last in the frame, NEXT goes to state MARK: rst_mark_req held high until rst_mark_ack, then → WAIT_SRC.
  - rst_mark_num increments after each ack and resets to 0 at start.
- When undefined: ports and state absent; NEXT behaviour as above.

Decomposition:
- Shared package jpeg_sched_pkg: state enum, component codes (COMP_Y/CB/CR), BLK_SAMPLES=64, block-to-component lookup function.
- One sub-module: jpeg_blk_counter (rd_idx counter with handshake advance and sob/eob flags).

Test Plan:
- 4:2:0, mcus_per_frame=2, all blk_valid=1, dct_ready=1 → rd_comp sequence Y,Y,Y,Y,Cb,Cr twice; 12 blk_ack pulses; mcu_done 2 pulses; frame_done once; 12×66+2 cycles total.
- dct_ready toggling 1,0 each cycle → rd_idx advances every other cycle; no index skipped or repeated; eob with idx 63.
- blk_valid[1]=0 held 20 cycles after 4th Y block → scheduler waits in WAIT_SRC, dct_valid=0, resumes when Cb valid; Cr valid earlier is not consumed out of order.
- mcus_per_frame=0, 4:4:4 → one MCU (3 blocks), qtab_sel 0,1,1, frame_done.
- Assert rst at rd_idx=30 → all outputs 0 next cycle, no blk_ack; new start streams from idx 0.
- With JPEG_SCHED_RESTART_EN, RST_INTERVAL=2, 5 MCUs → rst_mark_req after MCU 2 and 4 with num 0,1; none after MCU 5; stalls until ack.
